seq_shifter: RTL

Multi-cycle, parametrised shift/rotate unit for the datapath, successor to the single-bit combinational shifter. Shifts or rotates a WIDTH-bit operand by a variable amount, STEP bit positions per clock, under a start/busy/done handshake. Keeps the existing 5-bit shift opcode encoding. Sits beside the ALU and is sequenced by the control unit.

---
 rtl/seq_shifter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit: moves up to STEP bit positions per clock under a start/busy/done handshake.
// Optional macro SEQ_SHIFTER_CARRY_EN adds a registered carry_out holding the last bit shifted out.
module seq_shifter #(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [AMT_W-1:0] amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             illegal
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Low three opcode bits once the 10xxx prefix has been validated.
  localparam logic [2:0] K_ROR = 3'd0;
  localparam logic [2:0] K_ROL = 3'd1;
  localparam logic [2:0] K_LSR = 3'd2;
  localparam logic [2:0] K_ASR = 3'd4;

  logic [1:0]       r_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_work;
  logic [AMT_W-1:0] r_rem;
  logic [WIDTH-1:0] r_result;
  logic             r_illegal;

  logic             w_legal;
  logic             w_accept;
  logic             w_right;
  logic [AMT_W-1:0] w_step;
  logic [WIDTH-1:0] w_next;
  logic [(STEP+1)*WIDTH-1:0] w_cand_flat;

  assign w_legal  = (op[4:3] == 2'b10) && (op[2:0] <= 3'd5);
  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_right  = (r_op == K_ROR) || (r_op == K_LSR) || (r_op == K_ASR);
  assign w_step   = (r_rem < AMT_W'(STEP)) ? r_rem : AMT_W'(STEP);

  assign w_cand_flat[WIDTH-1:0] = r_work;

`ifdef SEQ_SHIFTER_CARRY_EN
  logic            r_carry;
  logic            r_carry_work;
  logic [STEP:0]   w_carry_vec;
  logic            w_next_c;
  assign w_carry_vec[0] = r_carry_work;
`endif

  // One candidate per possible step size; the current step picks one.
  for (genvar gi = 1; gi <= STEP; gi++) begin : g_cand
    logic [WIDTH-1:0] w_shift;
    always_comb begin
      case (r_op)
        K_ROR:   w_shift = {r_work[gi-1:0], r_work[WIDTH-1:gi]};
        K_ROL:   w_shift = {r_work[WIDTH-gi-1:0], r_work[WIDTH-1:WIDTH-gi]};
        K_LSR:   w_shift = {{gi{1'b0}}, r_work[WIDTH-1:gi]};
        K_ASR:   w_shift = {{gi{r_work[WIDTH-1]}}, r_work[WIDTH-1:gi]};
        default: w_shift = {r_work[WIDTH-gi-1:0], {gi{1'b0}}};
      endcase
    end
    assign w_cand_flat[gi*WIDTH +: WIDTH] = w_shift;
`ifdef SEQ_SHIFTER_CARRY_EN
    assign w_carry_vec[gi] = w_right ? r_work[gi-1] : r_work[WIDTH-gi];
`endif
  end

  always_comb begin
    w_next = r_work;
    for (int i = 0; i <= STEP; i++) begin
      if (w_step == AMT_W'(i)) begin
        w_next = w_cand_flat[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef SEQ_SHIFTER_CARRY_EN
  always_comb begin
    w_next_c = r_carry_work;
    for (int i = 0; i <= STEP; i++) begin
      if (w_step == AMT_W'(i)) begin
        w_next_c = w_carry_vec[i];
      end
    end
  end

  // Carry follows the working register step by step and is published on entry to DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_carry      <= 1'b0;
      r_carry_work <= 1'b0;
    end else if (w_accept) begin
      r_carry      <= 1'b0;
      r_carry_work <= 1'b0;
    end else if (r_state == ST_SHIFT) begin
      r_carry_work <= w_next_c;
      if (r_rem == w_step) begin
        r_carry <= w_next_c;
      end
    end
  end

  assign carry_out = r_carry;
`else
  logic w_unused_dir;
  assign w_unused_dir = w_right;
  assign carry_out    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_op      <= 3'd0;
      r_work    <= '0;
      r_rem     <= '0;
      r_result  <= '0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_op   <= op[2:0];
            r_work <= A;
            r_rem  <= amt;
            if (!w_legal || (amt == '0)) begin
              r_state   <= ST_DONE;
              r_result  <= A;
              r_illegal <= !w_legal;
            end else begin
              r_state <= ST_SHIFT;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          r_work <= w_next;
          r_rem  <= r_rem - w_step;
          if (r_rem == w_step) begin
            r_state   <= ST_DONE;
            r_result  <= w_next;
            r_illegal <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = (r_state == ST_SHIFT);
  assign done    = (r_state == ST_DONE);
  assign result  = r_result;
  assign illegal = r_illegal;

endmodule
